// File: rtl/wfunc_out_scale.sv
// wfunc_out_scale: rounds, shifts and saturates windowed FFT input samples from 32 to 16 bits.
// Results pass through a 2-entry output FIFO. Saturated beats are counted per packet, and a
// packet whose length is wrong is reported.
//
// Ports:
//   clk, rst               single clock, synchronous active-high reset
//   in_tvalid/in_tready    input beat handshake; in_tready depends only on registers and rst
//   in_tlast, in_tdata     BUS_NUM complex samples, per bus [1]=Im [0]=Re, signed 32-bit
//   out_tvalid/out_tready  output beat handshake
//   out_tlast, out_tdata   BUS_NUM complex samples, per bus [1]=Im [0]=Re, signed 16-bit
//   shift                  arithmetic right shift, clamped to 16, latched per packet
//   sat_cnt                saturated-beat count of the last completed packet
//   pkt_done               one-cycle pulse when a packet ends with tlast
//   len_err                one-cycle pulse on a packet length violation
module wfunc_out_scale #(
  parameter int unsigned FFT_SIZE = 8192,
  parameter int unsigned BUS_NUM  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_tvalid,
  output logic                    in_tready,
  input  logic                    in_tlast,
  input  logic [BUS_NUM*2*32-1:0] in_tdata,
  output logic                    out_tvalid,
  input  logic                    out_tready,
  output logic                    out_tlast,
  output logic [BUS_NUM*2*16-1:0] out_tdata,
  input  logic [4:0]              shift,
  output logic [15:0]             sat_cnt,
  output logic                    pkt_done,
  output logic                    len_err
);

  localparam int unsigned Beats   = FFT_SIZE / BUS_NUM;
  localparam int unsigned CntW    = $clog2(Beats) + 1;
  localparam int unsigned NumComp = BUS_NUM * 2;
  localparam int unsigned OutW    = NumComp * 16;
  localparam logic [CntW-1:0] LastIdx = CntW'(Beats - 1);

  // Returns {clipped, y}. Computes y = sat16((x + 2^(s-1)) >>> s) in 33 bits, so that the
  // rounding add can never overflow.
  function automatic logic [16:0] scale_comp(input logic [31:0] x, input logic [4:0] s);
    logic signed [32:0] xe;
    logic signed [32:0] rnd;
    logic signed [32:0] y;
    logic [16:0]        res;
    xe  = $signed({x[31], x});
    rnd = (s == 5'd0) ? 33'sd0 : (33'sd1 <<< (s - 5'd1));
    y   = (xe + rnd) >>> s;
    if (y > 33'sd32767) begin
      res = {1'b1, 16'h7FFF};
    end else if (y < -33'sd32768) begin
      res = {1'b1, 16'h8000};
    end else begin
      res = {1'b0, y[15:0]};
    end
    return res;
  endfunction

  // Packet state
  logic [CntW-1:0] beat_cnt_q;
  logic [15:0]     sat_acc_q;
  logic [15:0]     sat_acc_d;
  logic [15:0]     sat_cnt_q;
  logic [4:0]      shift_q;
  logic            pkt_done_q;
  logic            len_err_q;

  // Output FIFO
  logic [OutW:0]   mem_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      cnt_q;
  logic [1:0]      cnt_d;

  logic [4:0]      shift_clamp;
  logic [4:0]      shift_eff;
  logic [OutW-1:0] scaled;
  logic            beat_sat;
  logic [16:0]     comp_res;
  logic            push;
  logic            pop;
  logic            first_beat;
  logic            last_idx;

  assign in_tready  = ~rst & (cnt_q != 2'd2);
  assign out_tvalid = (cnt_q != 2'd0);
  assign {out_tlast, out_tdata} = mem_q[rd_ptr_q];
  assign sat_cnt    = sat_cnt_q;
  assign pkt_done   = pkt_done_q;
  assign len_err    = len_err_q;

  assign push       = in_tvalid & in_tready;
  assign pop        = out_tvalid & out_tready;
  assign first_beat = (beat_cnt_q == '0);
  assign last_idx   = (beat_cnt_q == LastIdx);

  // The first beat of a packet uses the live shift; later beats use the value latched with it.
  assign shift_clamp = (shift > 5'd16) ? 5'd16 : shift;
  assign shift_eff   = first_beat ? shift_clamp : shift_q;

  always_comb begin
    scaled   = '0;
    beat_sat = 1'b0;
    comp_res = '0;
    for (int i = 0; i < NumComp; i++) begin
      comp_res            = scale_comp(in_tdata[i*32 +: 32], shift_eff);
      scaled[i*16 +: 16]  = comp_res[15:0];
      beat_sat            = beat_sat | comp_res[16];
    end
  end

  assign sat_acc_d = (beat_sat && (sat_acc_q != 16'hFFFF)) ? sat_acc_q + 16'd1 : sat_acc_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
      beat_cnt_q <= '0;
      sat_acc_q  <= '0;
      sat_cnt_q  <= '0;
      shift_q    <= '0;
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      cnt_q      <= cnt_d;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (push) begin
        mem_q[wr_ptr_q] <= {in_tlast, scaled};
        wr_ptr_q        <= ~wr_ptr_q;
        if (first_beat) begin
          shift_q <= shift_clamp;
        end
        if (in_tlast || last_idx) begin
          // Packet boundary, either a proper end or a missing/early tlast.
          pkt_done_q <= in_tlast;
          len_err_q  <= ~(in_tlast & last_idx);
          sat_cnt_q  <= sat_acc_d;
          beat_cnt_q <= '0;
          sat_acc_q  <= '0;
        end else begin
          beat_cnt_q <= beat_cnt_q + 1'b1;
          sat_acc_q  <= sat_acc_d;
        end
      end
    end
  end

endmodule
